gcd_controller: RTL and testbench

- FSM controller that drives the 16-bit subtract-based GCD datapath.
- Sequences operand loading from the shared data_in bus.
- Runs the compare/subtract loop from the datapath's lt/gt/eq flags and reports completion to the host through a start/done handshake.
- The result is left in datapath register A.

---
 rtl/gcd_pkg.sv | 26 ++
 rtl/gcd_iter_cnt.sv | 41 ++++
 rtl/gcd_controller.sv | 150 +++++++++++++++
 tb/tb_gcd_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared constants for the subtract-based GCD controller: state encoding,
// datapath mux select values and the control-output bundle.
package gcd_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LD_A = 3'd1;
    localparam logic [2:0] LD_B = 3'd2;
    localparam logic [2:0] EVAL = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [2:0] ERR  = 3'd5;

    localparam logic SEL_A   = 1'b0;
    localparam logic SEL_B   = 1'b1;
    localparam logic BUS_DIN = 1'b1;
    localparam logic BUS_SUB = 1'b0;

    typedef struct packed {
        logic in_ready;
        logic ld_a;
        logic ld_b;
        logic sel1;
        logic sel2;
        logic sel_in;
    } ctrl_t;

endpackage

// File: rtl/gcd_iter_cnt.sv
// Subtraction-iteration counter: synchronous clear, saturating increment and
// a compare against the iteration limit.
module gcd_iter_cnt #(
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [ITER_W-1:0] count,
    output logic              at_limit
);

    localparam logic [ITER_W-1:0] LIMIT = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] ONE   = ITER_W'(1);

    logic [ITER_W-1:0] count_q;
    logic [ITER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q == LIMIT);

endmodule

// File: rtl/gcd_controller.sv
// FSM controller for the 16-bit subtract-based GCD datapath.
// Optional iteration timeout with ERR state: define GCD_TIMEOUT_EN.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              res_ack,
    input  logic              lt,
    input  logic              gt,
    input  logic              eq,
    output logic              ldA,
    output logic              ldB,
    output logic              sel1,
    output logic              sel2,
    output logic              sel_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ITER_W-1:0] iter_count
);

    logic [2:0] state_q;
    logic [2:0] state_d;
    ctrl_t      ctrl;
    logic       cnt_clr;
    logic       cnt_en;
    logic       at_limit;
    logic       done_c;
    logic       error_c;

    gcd_iter_cnt #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .count    (iter_count),
        .at_limit (at_limit)
    );

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        done_c  = 1'b0;
        error_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LD_A;
                    cnt_clr = 1'b1;
                end
            end
            LD_A: begin
                ctrl.in_ready = 1'b1;
                ctrl.sel_in   = BUS_DIN;
                if (in_valid) begin
                    ctrl.ld_a = 1'b1;
                    state_d   = LD_B;
                end
            end
            LD_B: begin
                ctrl.in_ready = 1'b1;
                ctrl.sel_in   = BUS_DIN;
                if (in_valid) begin
                    ctrl.ld_b = 1'b1;
                    state_d   = EVAL;
                end
            end
            EVAL: begin
                // Flag priority eq > gt > lt; no flag means hold without counting.
                if (eq) begin
                    state_d = DONE;
                end
`ifdef GCD_TIMEOUT_EN
                else if (at_limit) begin
                    state_d = ERR;
                end
`endif
                else if (gt) begin
                    ctrl.sel1   = SEL_A;
                    ctrl.sel2   = SEL_B;
                    ctrl.sel_in = BUS_SUB;
                    ctrl.ld_a   = 1'b1;
                    cnt_en      = 1'b1;
                end else if (lt) begin
                    ctrl.sel1   = SEL_B;
                    ctrl.sel2   = SEL_A;
                    ctrl.sel_in = BUS_SUB;
                    ctrl.ld_b   = 1'b1;
                    cnt_en      = 1'b1;
                end
            end
            DONE: begin
                done_c = 1'b1;
                if (res_ack) begin
                    state_d = IDLE;
                end
            end
`ifdef GCD_TIMEOUT_EN
            ERR: begin
                done_c  = 1'b1;
                error_c = 1'b1;
                if (res_ack) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_ready = ctrl.in_ready;
    assign ldA      = ctrl.ld_a;
    assign ldB      = ctrl.ld_b;
    assign sel1     = ctrl.sel1;
    assign sel2     = ctrl.sel2;
    assign sel_in   = ctrl.sel_in;
    assign busy     = (state_q != IDLE);
    assign done     = done_c;

`ifdef GCD_TIMEOUT_EN
    assign error = error_c;
`else
    logic unused_timeout;
    assign unused_timeout = at_limit | error_c;
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller with a behavioural 16-bit GCD datapath attached.
// Define GCD_TIMEOUT_EN to also exercise the ERR path (MAX_ITER = 16).
module tb_gcd_controller;

    localparam int ITER_W      = 16;
    localparam int TB_MAX_ITER = 16;
`ifdef GCD_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic res_ack = 1'b0;
    logic [15:0] data_in = '0;
    logic lt, gt, eq;
    logic in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, error;
    logic [ITER_W-1:0] iter_count;

    logic [15:0] a_reg = '0;
    logic [15:0] b_reg = '0;
    logic [15:0] minuend, subtrahend, bus;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    gcd_controller #(
        .ITER_W   (ITER_W),
        .MAX_ITER (TB_MAX_ITER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .res_ack    (res_ack),
        .lt         (lt),
        .gt         (gt),
        .eq         (eq),
        .ldA        (ldA),
        .ldB        (ldB),
        .sel1       (sel1),
        .sel2       (sel2),
        .sel_in     (sel_in),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .iter_count (iter_count)
    );

    // datapath: registers A/B, comparator on register outputs, muxed subtractor
    assign minuend    = sel1 ? b_reg : a_reg;
    assign subtrahend = sel2 ? b_reg : a_reg;
    assign bus        = sel_in ? data_in : (minuend - subtrahend);
    assign lt = (a_reg < b_reg);
    assign gt = (a_reg > b_reg);
    assign eq = (a_reg == b_reg);

    always @(posedge clk) begin
        if (ldA) a_reg <= bus;
        if (ldB) b_reg <= bus;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq(tag, {23'd0, in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, error}, 32'd0);
    endtask

    // reference: Euclid by repeated subtraction, with optional iteration cap
    task automatic ref_model(input int a, input int b, output int g, output int iters, output bit err);
        iters = 0;
        err   = 1'b0;
        while (a != b) begin
            if (TIMEOUT_ON && iters == TB_MAX_ITER) begin
                err = 1'b1;
                break;
            end
            if (a > b) a = a - b;
            else       b = b - a;
            iters++;
        end
        g = a;
    endtask

    task automatic run_gcd(input logic [15:0] a, input logic [15:0] b, input int da, input int db,
                           input int ack_delay, input bit poke);
        int g, iters, cycles, loads, guard;
        bit err;
        logic [15:0] exp_res;
        ref_model(a, b, g, iters, err);
        if (!err) exp_q.push_back(16'(g));

        @(negedge clk);
        start = 1'b1;
        cycles = 0;
        @(negedge clk);
        start = 1'b0;
        cycles++;
        for (int i = 0; i < da; i++) begin
            start = poke;
            in_valid = 1'b0;
            data_in = 16'($urandom);
            #1;
            check_eq("lda_wait_ready", in_ready, 1);
            check_eq("lda_wait_noload", {ldA, ldB}, 0);
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        in_valid = 1'b1;
        data_in = a;
        #1;
        check_eq("lda_load", {in_ready, ldA, ldB, sel_in}, 4'b1101);
        @(negedge clk);
        cycles++;
        for (int i = 0; i < db; i++) begin
            in_valid = 1'b0;
            data_in = 16'($urandom);
            #1;
            check_eq("ldb_wait_ready", in_ready, 1);
            check_eq("ldb_wait_noload", {ldA, ldB}, 0);
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b1;
        data_in = b;
        #1;
        check_eq("ldb_load", {in_ready, ldA, ldB, sel_in}, 4'b1011);
        @(negedge clk);
        cycles++;
        in_valid = 1'b0;
        data_in = 16'($urandom);
        #1;

        loads = 0;
        guard = 0;
        while (!done && guard < 2000) begin
            if (ldA) check_eq("sub_a_sel", {sel1, sel2, sel_in, ldB}, 4'b0100);
            if (ldB) check_eq("sub_b_sel", {sel1, sel2, sel_in, ldA}, 4'b1000);
            if (ldA || ldB) loads++;
            @(negedge clk);
            cycles++;
            guard++;
        end
        check_eq("done_reached", guard < 2000, 1);
        check_eq("latency", cycles, 3 + da + db + iters + 1);
        check_eq("iter_count", iter_count, iters);
        check_eq("load_cycles", loads, iters);
        check_eq("error_flag", error, err);
        check_eq("busy_in_done", busy, 1);
        if (!err && exp_q.size() > 0) begin
            exp_res = exp_q.pop_front();
            check_eq("result_a", a_reg, exp_res);
            check_eq("result_b", b_reg, exp_res);
        end

        for (int i = 0; i < ack_delay; i++) begin
            start = poke && (i == 2);
            #1;
            check_eq("done_hold", {done, error}, {1'b1, err});
            @(negedge clk);
        end
        start = 1'b0;
        res_ack = 1'b1;
        #1;
        check_eq("done_at_ack", done, 1);
        @(negedge clk);
        res_ack = 1'b0;
        #1;
        check_quiet("idle_after_ack");
        @(negedge clk);
        check_eq("still_idle", busy, 0);
    endtask

    task automatic reset_mid_eval();
        in_valid = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data_in = 16'd1000;
        @(negedge clk);
        data_in = 16'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("busy_pre_reset", busy, 1);
        check_eq("count_pre_reset", iter_count != 0, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("async_reset_outputs");
        check_eq("async_reset_count", iter_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_quiet("reset_outputs");
        check_eq("reset_count", iter_count, 0);
        rst_n = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        #1;
        check_quiet("idle_ignores_in_valid");
        in_valid = 1'b0;

        run_gcd(16'd48, 16'd18, 0, 0, 0, 1'b0);
        run_gcd(16'd7,  16'd7,  0, 0, 0, 1'b0);
        run_gcd(16'd21, 16'd14, 5, 3, 0, 1'b1);
        run_gcd(16'd48, 16'd18, 0, 0, 10, 1'b1);
        reset_mid_eval();
        run_gcd(16'd9,  16'd6,  0, 0, 0, 1'b0);
`ifdef GCD_TIMEOUT_EN
        run_gcd(16'd0,  16'd5,  0, 0, 2, 1'b0);
`endif
        for (int n = 0; n < 30; n++) begin
            run_gcd(16'($urandom_range(1, 255)), 16'($urandom_range(1, 255)),
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        end
        check_eq("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
